sp_ram_rr_arbiter: RTL and testbench

//  Shares one synchronous single-port N x 32bit byte-enable RAM between NUM_PORTS requesters.

---
 rtl/sp_ram_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_sp_ram_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit byte-enable RAM between NUM_PORTS
// requesters. Grants are combinational; every granted access returns an in-order response
// pulse RAM_LAT = 1 + OUT_REGS cycles later.
module sp_ram_rr_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned OUT_REGS   = 0
) (
    input  logic                            Clk_CI,
    input  logic                            Rst_RBI,
    input  logic [NUM_PORTS-1:0]            Req_SI,
    output logic [NUM_PORTS-1:0]            Gnt_SO,
    input  logic [NUM_PORTS-1:0]            WrEn_SI,
    input  logic [NUM_PORTS*4-1:0]          BEn_SI,
    input  logic [NUM_PORTS*32-1:0]         WrData_DI,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] Addr_DI,
    output logic [NUM_PORTS-1:0]            RValid_SO,
    output logic [31:0]                     RdData_DO,
    output logic                            RamCSel_SO,
    output logic                            RamWrEn_SO,
    output logic [3:0]                      RamBEn_SO,
    output logic [31:0]                     RamWrData_DO,
    output logic [ADDR_WIDTH-1:0]           RamAddr_DO,
    input  logic [31:0]                     RamRdData_DI
);

    localparam int unsigned RamLat = 1 + OUT_REGS;
    localparam int unsigned IdW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : gen_bad_num_ports
        $error("sp_ram_rr_arbiter: NUM_PORTS must be in 2..8");
    end

    logic [IdW-1:0]       ptr_q, ptr_d;
    logic                 any_gnt;
    logic [IdW-1:0]       gnt_id;
    logic [NUM_PORTS-1:0] gnt;
    logic [RamLat-1:0]    vld_q;
    logic [IdW-1:0]       id_q [RamLat];

    // Search ptr, ptr+1, ... for the first requester; no grant while reset is held.
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(ptr_q) + k) % NUM_PORTS;
            if (!any_gnt && Req_SI[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IdW'(idx);
            end
        end
        if (!Rst_RBI) begin
            gnt     = '0;
            any_gnt = 1'b0;
        end
        ptr_d = any_gnt ? IdW'((32'(gnt_id) + 1) % NUM_PORTS) : ptr_q;
    end

    assign Gnt_SO = gnt;

    // Steer the granted port's payload to the RAM; everything idles at zero otherwise.
    always_comb begin
        RamCSel_SO   = any_gnt;
        RamWrEn_SO   = 1'b0;
        RamBEn_SO    = '0;
        RamWrData_DO = '0;
        RamAddr_DO   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                RamWrEn_SO   = WrEn_SI[i];
                RamBEn_SO    = BEn_SI[i*4 +: 4];
                RamWrData_DO = WrData_DI[i*32 +: 32];
                RamAddr_DO   = Addr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Priority pointer and {valid, id} shift register tracking the RAM latency.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            ptr_q <= '0;
            vld_q <= '0;
            for (int unsigned i = 0; i < RamLat; i++) id_q[i] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= any_gnt;
            id_q[0]  <= gnt_id;
            for (int unsigned i = 1; i < RamLat; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    // Decode the oldest pipeline stage into a one-hot response pulse.
    always_comb begin
        RValid_SO = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            RValid_SO[i] = vld_q[RamLat-1] && (id_q[RamLat-1] == IdW'(i));
        end
    end

    assign RdData_DO = RamRdData_DI;

`ifndef SYNTHESIS
    logic [NUM_PORTS-1:0]            pend_q;
    logic [NUM_PORTS-1:0]            wren_q;
    logic [NUM_PORTS*4-1:0]          ben_q;
    logic [NUM_PORTS*32-1:0]         wdata_q;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_q;

    // Protocol checks: one-hot grants/responses, grant only on request, stable pending payload.
    always_ff @(posedge Clk_CI) begin
        pend_q  <= Rst_RBI ? (Req_SI & ~Gnt_SO) : '0;
        wren_q  <= WrEn_SI;
        ben_q   <= BEn_SI;
        wdata_q <= WrData_DI;
        addr_q  <= Addr_DI;
        if (Rst_RBI) begin
            assert ($onehot0(Gnt_SO)) else $error("Gnt_SO not onehot0");
            assert ($onehot0(RValid_SO)) else $error("RValid_SO not onehot0");
            assert ((Gnt_SO & ~Req_SI) == '0) else $error("grant without request");
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (pend_q[i] && Req_SI[i]) begin
                    assert (WrEn_SI[i] == wren_q[i] && BEn_SI[i*4 +: 4] == ben_q[i*4 +: 4] &&
                            WrData_DI[i*32 +: 32] == wdata_q[i*32 +: 32] &&
                            Addr_DI[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                            addr_q[i*ADDR_WIDTH +: ADDR_WIDTH])
                        else $error("payload changed while request pending");
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Bench for sp_ram_rr_arbiter: directed scenarios plus random traffic against a behavioural
// RAM, with a queue-based scoreboard checking grants, RAM drive and in-order responses.
module tb_sp_ram_rr_arbiter;

    localparam int NP  = 4;
    localparam int AW  = 10;
    localparam int OR  = 1;
    localparam int LAT = 1 + OR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] req = '0, we = '0;
    logic [3:0]    ben  [NP];
    logic [31:0]   wdat [NP];
    logic [AW-1:0] addr [NP];
    logic [NP*4-1:0]  ben_flat;
    logic [NP*32-1:0] wdat_flat;
    logic [NP*AW-1:0] addr_flat;

    logic [NP-1:0] gnt, rvalid;
    logic [31:0]   rdata, ram_wdata, ram_rdata;
    logic          ram_csel, ram_we;
    logic [3:0]    ram_ben;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            ben_flat[p*4 +: 4]    = ben[p];
            wdat_flat[p*32 +: 32] = wdat[p];
            addr_flat[p*AW +: AW] = addr[p];
        end
    end

    sp_ram_rr_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .OUT_REGS(OR)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt), .WrEn_SI(we),
        .BEn_SI(ben_flat), .WrData_DI(wdat_flat), .Addr_DI(addr_flat), .RValid_SO(rvalid),
        .RdData_DO(rdata), .RamCSel_SO(ram_csel), .RamWrEn_SO(ram_we), .RamBEn_SO(ram_ben),
        .RamWrData_DO(ram_wdata), .RamAddr_DO(ram_addr), .RamRdData_DI(ram_rdata)
    );

    // Behavioural synchronous single-port byte-enable RAM with OR output registers.
    logic [31:0] mem [1 << AW];
    logic [31:0] rd0_q, rd1_q;
    always @(posedge clk) begin
        if (ram_csel) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_ben[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                rd0_q <= mem[ram_addr];
            end
        end
        rd1_q <= rd0_q;
    end
    assign ram_rdata = (OR != 0) ? rd1_q : rd0_q;

    int n_vec = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {int port; bit rd; logic [31:0] data; int due;} exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd [NP];
    int          mptr = 0;

    // Reference model: rotating-priority pick, RAM drive check, expected response enqueue.
    always @(negedge clk) begin
        logic [NP-1:0] eg;
        int            gi;
        logic [31:0]   old;
        eg = '0;
        gi = -1;
        if (!rst_n) begin
            mptr = 0;
        end else begin
            for (int k = 0; k < NP; k++)
                if (gi < 0 && req[(mptr + k) % NP]) gi = (mptr + k) % NP;
            if (gi >= 0) eg[gi] = 1'b1;
        end
        check(gnt == eg, "grant", 32'(gnt), 32'(eg));
        check(ram_csel == (gi >= 0), "ram_csel", 32'(ram_csel), 32'(gi >= 0));
        if (gi >= 0) begin
            check(ram_we == we[gi] && ram_ben == ben[gi], "ram_ctl",
                  {ram_we, 27'd0, ram_ben}, {we[gi], 27'd0, ben[gi]});
            check(ram_addr == addr[gi], "ram_addr", 32'(ram_addr), 32'(addr[gi]));
            if (we[gi]) check(ram_wdata == wdat[gi], "ram_wdata", ram_wdata, wdat[gi]);
            old = ref_mem.exists(int'(addr[gi])) ? ref_mem[int'(addr[gi])] : 32'h0;
            sb.push_back('{port: gi, rd: !we[gi], data: old, due: cyc + LAT});
            if (we[gi]) begin
                for (int b = 0; b < 4; b++) if (ben[gi][b]) old[b*8 +: 8] = wdat[gi][b*8 +: 8];
                ref_mem[int'(addr[gi])] = old;
            end
            mptr = (gi + 1) % NP;
        end else begin
            check(ram_we == 1'b0 && ram_ben == 4'h0 && ram_wdata == 32'h0 && ram_addr == '0,
                  "ram_idle", {ram_we, 27'd0, ram_ben}, 32'h0);
        end
    end

    // Monitor: pops the scoreboard when a response is due, otherwise demands silence.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            check(rvalid == '0, "rvalid_rst", 32'(rvalid), 32'h0);
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check(rvalid == NP'(1 << e.port), "rvalid", 32'(rvalid), 32'(1 << e.port));
            if (e.rd) begin
                check(rdata == e.data, "rdata", rdata, e.data);
                last_rd[e.port] = rdata;
            end
        end else begin
            check(rvalid == '0, "rvalid_idle", 32'(rvalid), 32'h0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [3:0] be,
                            input logic [31:0] d, input logic [AW-1:0] a);
        req[p] = r; we[p] = w; ben[p] = be; wdat[p] = d; addr[p] = a;
    endtask

    // One access from port p, holding the request until granted (bounded wait).
    task automatic do_access(input int p, input bit w, input logic [3:0] be,
                             input logic [31:0] d, input logic [AW-1:0] a);
        bit got = 1'b0;
        set_port(p, 1'b1, w, be, d, a);
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = gnt[p];
        end
        check(got, "grant_timeout", 32'(got), 32'h1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] g;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        for (int p = 0; p < NP; p++) begin
            set_port(p, 1'b0, 1'b0, 4'h0, 32'h0, '0);
            last_rd[p] = 32'h0;
        end
        step(3);
        rst_n = 1'b1;
        step(10);

        do_access(0, 1'b1, 4'hF, 32'hDEADBEEF, 10'd5);
        do_access(1, 1'b0, 4'h0, 32'h0, 10'd5);
        step(LAT + 2);
        check(last_rd[1] == 32'hDEADBEEF, "rd_deadbeef", last_rd[1], 32'hDEADBEEF);

        do_access(0, 1'b1, 4'hF, 32'h11223344, 10'd7);
        do_access(1, 1'b1, 4'h2, 32'h0000AA00, 10'd7);
        do_access(2, 1'b0, 4'h0, 32'h0, 10'd7);
        step(LAT + 2);
        check(last_rd[2] == 32'h1122AA44, "rd_merged", last_rd[2], 32'h1122AA44);

        reset_pulse();
        set_port(0, 1'b1, 1'b0, 4'h0, 32'h0, 10'd5);
        set_port(1, 1'b1, 1'b0, 4'h0, 32'h0, 10'd7);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check(gnt == ((k % 2) ? 4'b0010 : 4'b0001), "alt_2", 32'(gnt), 32'(k % 2 + 1));
            @(posedge clk); #1;
        end
        req = '0;
        step(LAT + 2);

        reset_pulse();
        set_port(1, 1'b1, 1'b0, 4'h0, 32'h0, 10'd1);
        set_port(3, 1'b1, 1'b0, 4'h0, 32'h0, 10'd3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check(gnt == ((k % 2) ? 4'b1000 : 4'b0010), "alt_1010", 32'(gnt),
                  (k % 2) ? 32'h8 : 32'h2);
            @(posedge clk); #1;
        end
        req = '0;
        step(LAT + 2);

        // Reset with two reads in flight; pointer would otherwise favour port 2.
        reset_pulse();
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 4'h0, 32'h0, AW'(p));
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        reset_pulse();
        @(negedge clk);
        check(gnt == 4'b0001, "gnt_after_rst", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        req = '0;
        step(LAT + 4);

        // Random traffic: new requests after grants, occasional withdrawals.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                if (!req[p] || g[p]) begin
                    set_port(p, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                             4'($urandom), $urandom, AW'($urandom_range(0, 15)));
                end else if ($urandom_range(0, 19) == 0) begin
                    req[p] = 1'b0;
                end
            end
        end
        req = '0;
        step(LAT + 4);
        check(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
